// File: rtl/types_pkg.sv
// Shared fetch-path types and constants.
// Imported by the fetch unit, its response buffer and the bench.
package types_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FIFO_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, decode and redirect signals of the fetch unit.
// The fetch unit is the master; memory, decode and branch logic form the slave.
interface fetch_unit_if;

    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_en, imem_addr, instr, pc_out, valid_out,
        input  imem_rdata, ready_out, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, instr, pc_out, valid_out,
        output imem_rdata, ready_out, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry response buffer between instruction memory and decode.
// Flush has priority over push and pop; push and pop may coincide at any occupancy.
module fetch_fifo
    import types_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_data        push_data,
    input  logic             pop,
    output fetch_data        head,
    output logic             not_empty,
    output logic [CNT_W-1:0] count
);

    fetch_data mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            // Stale payload stays in mem; it is never visible because count is zero.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-based request issue,
// one-cycle memory response capture and a two-entry buffer toward decode.
module fetch_unit
    import types_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master fu
);

    localparam int STAGES = 1;

    // vld_pipe[0]: request issued this cycle; vld_pipe[1]: its response arrives now.
    logic [STAGES:0] vld_pipe;
    logic            inflight;
    logic            issue;
    logic            pop;
    logic            push;
    logic            discard;
    logic [2:0]      occ;
    logic [31:0]     fetch_pc;
    logic [31:0]     req_pc;

    fetch_data       head;
    fetch_data       push_data;
    logic            fifo_valid;
    logic [1:0]      fifo_count;

    assign vld_pipe = {inflight, issue};

    // Masking with reset keeps decode quiet for the whole reset window, not just after the first edge.
    assign fu.valid_out = fifo_valid & ~reset;
    assign pop          = fu.valid_out & fu.ready_out;

    // Credit check: entries held plus the response on the wire, minus what decode takes now.
    assign occ   = {1'b0, fifo_count} + {2'b00, vld_pipe[1]} - {2'b00, pop};
    assign issue = ~reset & ~fu.redirect_valid & (occ < 3'd2);

    // A response landing in a redirect cycle belongs to the old path.
    assign discard   = vld_pipe[1] & fu.redirect_valid;
    assign push      = vld_pipe[1] & ~discard;
    assign push_data = '{pc: req_pc, instr: fu.imem_rdata};

    assign fu.imem_en   = vld_pipe[0];
    assign fu.imem_addr = fetch_pc;
    assign fu.instr     = fu.valid_out ? head.instr : '0;
    assign fu.pc_out    = fu.valid_out ? head.pc    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (fu.redirect_valid) begin
                fetch_pc <= align_pc(fu.redirect_pc);
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fu.redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, response buffer entries; only 2 is supported.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 imem_en  output  1  instruction memory read request this cycle.
REQ-006 imem_addr  output  32  word-aligned read address; valid when imem_en=1.
REQ-007 imem_rdata  input  32  read data; valid exactly one cycle after the imem_en=1 cycle.
REQ-008 instr  output  32  instruction sent to decode.
REQ-009 pc_out  output  32  PC of instr.
REQ-010 valid_out  output  1  instr/pc_out valid.
REQ-011 ready_out  input  1  decode can accept this cycle.
REQ-012 redirect_valid  input  1  flush pipeline front and restart fetch.
REQ-013 redirect_pc  input  32  restart address; bits [1:0] ignored.

Function
REQ-014 fetch_pc register; a request drives imem_en=1, imem_addr=fetch_pc, then fetch_pc <= fetch_pc+4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-015 Request issued iff !redirect_valid && (fifo_count + inflight - pop) < 2, where pop = valid_out && ready_out.
REQ-016 inflight = 1 in the cycle after a request; that cycle's {fetch address, imem_rdata} is pushed into the FIFO unless discarded.
REQ-017 valid_out = FIFO non-empty; instr/pc_out = FIFO head; both stay stable while valid_out=1 and ready_out=0.
REQ-018 Transfer occurs on valid_out && ready_out; head pops at that edge.
REQ-019 Push and pop in the same cycle are legal at any occupancy; FIFO never overflows (guaranteed by REQ-015).
REQ-020 Latency: request cycle N -> push at end of N+1 -> valid_out in N+2.
REQ-021 Throughput: with ready_out held 1, one instruction per cycle, consecutive PCs differing by 4.
REQ-022 Redirect (priority over push, pop and issue): FIFO flushed; in-flight response marked discard and not pushed; fetch_pc <= {redirect_pc[31:2],2'b00}; imem_en=0 in the redirect cycle.
REQ-023 valid_out=0 in the cycle after a redirect; first request to redirect_pc issued in that same cycle; first redirected instruction valid two cycles later.
REQ-024 Back-to-back redirects: each one restarts the sequence; only the last target is fetched.
REQ-025 A transfer with redirect_valid=1 in the same cycle still counts as accepted by decode; fetch does not replay it.
REQ-026 ready_out has no combinational path to imem_en beyond REQ-015; valid_out has no combinational dependence on ready_out.

Reset
REQ-027 While reset=1: imem_en=0, valid_out=0, instr=0, pc_out=0, fifo_count=0, inflight=0, discard=0, fetch_pc=RESET_PC.
REQ-028 First request (address RESET_PC) issued in the first cycle with reset=0.
REQ-029 Reset asserted mid-operation drops all in-flight and buffered instructions; no response returned after reset is pushed.

Structure
REQ-030 types_pkg holds typedef fetch_data {pc[31:0], instr[31:0]} and constant RESET_PC_DEFAULT.
REQ-031 Buffer is sub-module fetch_fifo (2-entry, flush input, fetch_data payload); PC/credit/discard logic lives in fetch_unit.

Verification
REQ-032 Reset release, ready_out=1, memory word = address: pc_out/instr 0x0,0x4,0x8... on consecutive cycles starting cycle 2.
REQ-033 ready_out=0 for 5 cycles after first valid: valid_out stays 1, pc_out=0x0 stable, imem_en stops after 2 outstanding; resume gives 0x0,0x4,0x8 without gap or duplicate.
REQ-034 redirect_valid with redirect_pc=0x0000_0103 while FIFO full and request in flight: next cycle valid_out=0, imem_addr=0x100; 0x100 is the next pc_out; old PCs never appear.
REQ-035 Redirect to 0xFFFF_FFF8, ready_out=1: pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 Random ready_out and redirects vs reference PC model: every transferred pc_out matches the model, no loss, no duplication, no push of a discarded response.
REQ-037 Reset asserted with 2 buffered entries: valid_out=0 the following cycle; after release, first pc_out=RESET_PC.
